// File: rtl/branch_cond_ctrl.sv
// branch_cond_ctrl: conditional-branch sequencer driving the flag mux, ALU compare and PC-write pulse
// Ports: clk/reset (async, active-high); start+opcode request from the main FSM;
//  flag_or/flag_gt/flag_zero/flag_nzero ALU flags; cnt_clr clears taken_cnt;
//  alu_sub, flag_sel, busy, done, pc_write_cond, illegal, taken_cnt outputs.
module branch_cond_ctrl #(
  parameter int         CNT_W  = 16,
  parameter logic [5:0] OP_BEQ = 6'h04,
  parameter logic [5:0] OP_BNE = 6'h05,
  parameter logic [5:0] OP_BLE = 6'h06,
  parameter logic [5:0] OP_BGT = 6'h07
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             flag_or,
  input  logic             flag_gt,
  input  logic             flag_zero,
  input  logic             flag_nzero,
  input  logic             cnt_clr,
  output logic             alu_sub,
  output logic [1:0]       flag_sel,
  output logic             busy,
  output logic             done,
  output logic             pc_write_cond,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_cnt
);
  typedef enum logic [1:0] {IDLE, SETUP, COMMIT} state_t;
  state_t           state_q, state_d;
  logic [1:0]       flag_sel_q, flag_sel_d, dec_sel;
  logic             illegal_q, illegal_d, taken_q, taken_d;
  logic             accept, dec_ok, flag_mux;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (dec_ok ? SETUP : COMMIT) : IDLE;
      SETUP:   state_d = COMMIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_sub       = state_q == SETUP;
    busy          = state_q != IDLE;
    done          = state_q == COMMIT;
    pc_write_cond = done & taken_q & ~illegal_q;
    illegal       = done & illegal_q;
    flag_sel      = flag_sel_q;
    taken_cnt     = cnt_q;
  end

  always_comb begin
    accept   = (state_q == IDLE) & start;
    dec_ok   = (opcode == OP_BEQ) | (opcode == OP_BNE) | (opcode == OP_BLE) | (opcode == OP_BGT);
    dec_sel  = (opcode == OP_BEQ) ? 2'b10 :
               (opcode == OP_BNE) ? 2'b11 :
               (opcode == OP_BLE) ? 2'b00 : 2'b01;
    flag_mux = flag_sel_q[1] ? (flag_sel_q[0] ? flag_nzero : flag_zero)
                             : (flag_sel_q[0] ? flag_gt    : flag_or);
    // flags only reach state on the SETUP edge, so unknown flags elsewhere stay contained
    taken_d    = (state_q == SETUP) ? flag_mux : accept ? 1'b0 : taken_q;
    flag_sel_d = (accept & dec_ok) ? dec_sel : flag_sel_q;
    illegal_d  = accept ? ~dec_ok : illegal_q;
    // clear beats increment; saturate at all-ones
    cnt_d      = cnt_clr ? '0 : (pc_write_cond & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      flag_sel_q <= 2'b00;
      illegal_q  <= 1'b0;
      taken_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      flag_sel_q <= flag_sel_d;
      illegal_q  <= illegal_d;
      taken_q    <= taken_d;
      cnt_q      <= cnt_d;
    end
endmodule
